// File: rtl/col_parity_stage.sv
// Column-parity (theta) stage: streams 64 slices from a source memory, XORs in
// neighbouring column parities and writes each result slice to a destination memory.
module col_parity_stage #(
   parameter int SLICES = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [24:0]       rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [24:0]       wr_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_Z = ADDR_W'(SLICES - 1);

   typedef enum logic [2:0] {IDLE, RD_LAST, PRIME, PROC, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] z_q, z_d;
   logic [4:0]        p_q, p_d;
   logic [24:0]       wr_data_q, wr_data_d;
   logic [24:0]       theta_out;

   function automatic logic [4:0] col_parity(input logic [24:0] s);
      logic [4:0] c;
      for (int x = 0; x < 5; x++) begin
         c[x] = s[x] ^ s[x+5] ^ s[x+10] ^ s[x+15] ^ s[x+20];
      end
      return c;
   endfunction

   // p is the column-parity vector of the previous slice (z-1)
   function automatic logic [24:0] theta(input logic [24:0] s, input logic [4:0] p);
      logic [4:0]  c;
      logic [24:0] r;
      c = col_parity(s);
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            r[5*y+x] = s[5*y+x] ^ c[(x+4)%5] ^ p[(x+1)%5];
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      z_d       = z_q;
      p_d       = p_q;
      wr_data_d = wr_data_q;
      theta_out = theta(rd_data, p_q);
      rd_en     = 1'b0;
      rd_addr   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = wr_data_q;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RD_LAST;
         end
         RD_LAST: begin
            busy    = 1'b1;
            rd_en   = 1'b1;
            rd_addr = LAST_Z;
            state_d = PRIME;
         end
         PRIME: begin
            // slice SLICES-1 seeds P so slice 0 sees its wrap-around neighbour
            busy    = 1'b1;
            p_d     = col_parity(rd_data);
            rd_en   = 1'b1;
            rd_addr = '0;
            z_d     = '0;
            state_d = PROC;
         end
         PROC: begin
            busy      = 1'b1;
            wr_en     = 1'b1;
            wr_addr   = z_q;
            wr_data   = theta_out;
            wr_data_d = theta_out;
            p_d       = col_parity(rd_data);
            if (z_q != LAST_Z) begin
               rd_en   = 1'b1;
               rd_addr = z_q + 1'b1;
               z_d     = z_q + 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         z_q       <= '0;
         p_q       <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         z_q       <= z_d;
         p_q       <= p_d;
         wr_data_q <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_col_parity_stage.sv
// Directed bench for col_parity_stage: table of whole-pass vectors plus
// hand-written sequences for restart and mid-pass reset.
module tb_col_parity_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [24:0] rd_data = '0;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [24:0] wr_data;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   col_parity_stage #(.SLICES(64), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   logic [24:0] src [64];
   logic [24:0] dst [64];
   int          dcnt [64];

   always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

   logic       busy_log [256];
   logic       done_log [256];
   logic       rden_log [256];
   logic       wren_log [256];
   logic [5:0] rda_log  [256];

   int vecs  = 0;
   int fails = 0;

   typedef struct {
      logic [24:0] s0;
      logic [24:0] s63;
      logic [24:0] fill;
      int          a_addr;
      logic [24:0] a_exp;
      int          b_addr;
      logic [24:0] b_exp;
      logic [24:0] other;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic load(input vec_t v);
      for (int i = 0; i < 64; i++) src[i] = v.fill;
      src[0]  = v.s0;
      src[63] = v.s63;
   endtask

   // n_cyc cycles; cycle 0 carries the first start
   task automatic run(input int n_cyc, input int st_a, input int st_b, input int st_c, input int rst_at);
      for (int i = 0; i < 64; i++) begin
         dcnt[i] = 0;
         dst[i]  = '0;
      end
      for (int n = 0; n < n_cyc; n++) begin
         @(negedge clk);
         busy_log[n] = busy;
         done_log[n] = done;
         rden_log[n] = rd_en;
         wren_log[n] = wr_en;
         rda_log[n]  = rd_addr;
         if (wr_en) begin
            dst[wr_addr] = wr_data;
            dcnt[wr_addr]++;
         end
         start = (n == 0) || (n == st_a) || (n == st_b) || (n == st_c);
         rst   = (n == rst_at);
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
   endtask

   function automatic int count_log(input int which, input int lo, input int hi);
      int c = 0;
      for (int n = lo; n <= hi; n++) begin
         if (which == 0 && wren_log[n]) c++;
         if (which == 1 && done_log[n]) c++;
      end
      return c;
   endfunction

   task automatic check_pass(input int idx, input vec_t v);
      logic [24:0] e;
      chk($sformatf("v%0d_writes", idx), 32'(count_log(0, 0, 79)), 32'd64);
      chk($sformatf("v%0d_done67", idx), {31'd0, done_log[67]}, 32'd1);
      chk($sformatf("v%0d_ndone", idx), 32'(count_log(1, 0, 79)), 32'd1);
      for (int a = 0; a < 64; a++) begin
         e = (a == v.a_addr) ? v.a_exp : (a == v.b_addr) ? v.b_exp : v.other;
         chk($sformatf("v%0d_addr%0d", idx, a), {dcnt[a][6:0], dst[a]}, {7'd1, e});
      end
   endtask

   initial begin
      tbl[0] = '{s0: 25'h0,       s63: 25'h0,       fill: 25'h0,       a_addr: -1, a_exp: 25'h0,
                 b_addr: -1, b_exp: 25'h0,       other: 25'h0};
      tbl[1] = '{s0: 25'h0000001, s63: 25'h0,       fill: 25'h0,       a_addr: 0,  a_exp: 25'h0210843,
                 b_addr: 1,  b_exp: 25'h1084210, other: 25'h0};
      tbl[2] = '{s0: 25'h0,       s63: 25'h0000001, fill: 25'h0,       a_addr: 0,  a_exp: 25'h1084210,
                 b_addr: 63, b_exp: 25'h0210843, other: 25'h0};
      tbl[3] = '{s0: 25'h1FFFFFF, s63: 25'h1FFFFFF, fill: 25'h1FFFFFF, a_addr: -1, a_exp: 25'h0,
                 b_addr: -1, b_exp: 25'h0,       other: 25'h1FFFFFF};

      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en",   {31'd0, rd_en},  32'd0);
      chk("rst_wr_en",   {31'd0, wr_en},  32'd0);
      chk("rst_busy",    {31'd0, busy},   32'd0);
      chk("rst_done",    {31'd0, done},   32'd0);
      chk("rst_rd_addr", {26'd0, rd_addr}, 32'd0);
      chk("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", {7'd0, wr_data}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         load(tbl[i]);
         run(80, -1, -1, -1, -1);
         check_pass(i, tbl[i]);
      end
      chk("hold_wr_data", {7'd0, wr_data}, {7'd0, 25'h1FFFFFF});

      // stray starts at 5 (busy) and 67 (DONE) ignored; start at 68 accepted
      load(tbl[1]);
      run(150, 5, 67, 68, -1);
      chk("seq_busy0",     {31'd0, busy_log[0]},  32'd0);
      chk("seq_busy1",     {31'd0, busy_log[1]},  32'd1);
      chk("seq_busy66",    {31'd0, busy_log[66]}, 32'd1);
      chk("seq_busy67",    {31'd0, busy_log[67]}, 32'd0);
      chk("seq_busy68",    {31'd0, busy_log[68]}, 32'd0);
      chk("seq_busy69",    {31'd0, busy_log[69]}, 32'd1);
      chk("seq_rda1",      {26'd0, rda_log[1]},   32'd63);
      chk("seq_rda2",      {26'd0, rda_log[2]},   32'd0);
      chk("seq_rda65",     {26'd0, rda_log[65]},  32'd63);
      chk("seq_rden66",    {31'd0, rden_log[66]}, 32'd0);
      chk("seq_wren2",     {31'd0, wren_log[2]},  32'd0);
      chk("seq_wren3",     {31'd0, wren_log[3]},  32'd1);
      chk("seq_writes_p1", 32'(count_log(0, 0, 67)),  32'd64);
      chk("seq_done_p1",   32'(count_log(1, 0, 134)), 32'd1);
      chk("seq_done67",    {31'd0, done_log[67]},  32'd1);
      chk("seq_done135",   {31'd0, done_log[135]}, 32'd1);
      chk("seq_writes_all", 32'(count_log(0, 0, 149)), 32'd128);

      // reset asserted in cycle 20 aborts the pass
      run(100, -1, -1, -1, 20);
      chk("rst_wren21",  {31'd0, wren_log[21]}, 32'd0);
      chk("rst_busy21",  {31'd0, busy_log[21]}, 32'd0);
      chk("rst_rden21",  {31'd0, rden_log[21]}, 32'd0);
      chk("rst_ndone",   32'(count_log(1, 0, 99)), 32'd0);
      chk("rst_writes",  32'(count_log(0, 0, 99)), 32'd18);
      run(80, -1, -1, -1, -1);
      check_pass(4, tbl[1]);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
